// File: rtl/rails_result_packer.sv
// Packs rails-checker verdicts LSB-first into words, queues them in a small
// FIFO toward the host and keeps saturating pass/fail totals.
module rails_result_packer #(
   parameter int PACK_W     = 8,
   parameter int FIFO_DEPTH = 4,
   parameter int CNT_W      = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   input  logic              in_result,
   input  logic              flush,
   input  logic              out_ready,
   output logic              out_valid,
   output logic [PACK_W-1:0] out_data,
   output logic [3:0]        out_count,
   output logic [CNT_W-1:0]  pass_cnt,
   output logic [CNT_W-1:0]  fail_cnt,
   output logic              overflow,
   output logic              busy
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [3:0] LAST = 4'(PACK_W - 1);

   typedef enum logic [1:0] {IDLE, COLLECT, HOLD} state_t;

   state_t            state_q, state_d;
   logic [3:0]        bit_idx_q, bit_idx_d;
   logic [PACK_W-1:0] shreg_q, shreg_d;
   logic [PACK_W-1:0] hold_data_q, hold_data_d;
   logic [3:0]        hold_cnt_q, hold_cnt_d;
   logic              ovf_q, ovf_d;
   logic [CNT_W-1:0]  pass_q, fail_q;

   logic [AW:0]       wr_ptr_q, rd_ptr_q;
   logic [PACK_W-1:0] fifo_data_q [FIFO_DEPTH];
   logic [3:0]        fifo_cnt_q  [FIFO_DEPTH];

   logic              empty, full, pop, space;
   logic              push;
   logic [PACK_W-1:0] push_data;
   logic [3:0]        push_cnt;
   logic              done;
   logic [PACK_W-1:0] done_data;
   logic [3:0]        done_cnt;
   logic [PACK_W-1:0] packed_w;

   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign pop   = !empty && out_ready;
   // A same-cycle pop frees a slot, so a full FIFO can still take a push.
   assign space = !full || pop;

   assign packed_w = shreg_q |
      ({{(PACK_W-1){1'b0}}, in_result} << bit_idx_q);

   always_comb begin
      state_d     = state_q;
      bit_idx_d   = bit_idx_q;
      shreg_d     = shreg_q;
      hold_data_d = hold_data_q;
      hold_cnt_d  = hold_cnt_q;
      ovf_d       = ovf_q;
      push        = 1'b0;
      push_data   = '0;
      push_cnt    = '0;
      done        = 1'b0;
      done_data   = '0;
      done_cnt    = '0;
      unique case (state_q)
         IDLE, COLLECT: begin
            if (in_valid) begin
               if (bit_idx_q == LAST || flush) begin
                  done      = 1'b1;
                  done_data = packed_w;
                  done_cnt  = 4'(bit_idx_q + 4'd1);
               end else begin
                  shreg_d   = packed_w;
                  bit_idx_d = 4'(bit_idx_q + 4'd1);
                  state_d   = COLLECT;
               end
            end else if (flush && bit_idx_q != 4'd0) begin
               done      = 1'b1;
               done_data = shreg_q;
               done_cnt  = bit_idx_q;
            end
            if (done) begin
               bit_idx_d = '0;
               shreg_d   = '0;
               if (space) begin
                  push      = 1'b1;
                  push_data = done_data;
                  push_cnt  = done_cnt;
                  state_d   = IDLE;
               end else begin
                  hold_data_d = done_data;
                  hold_cnt_d  = done_cnt;
                  state_d     = HOLD;
               end
            end
         end
         HOLD: begin
            if (in_valid) ovf_d = 1'b1;
            if (space) begin
               push      = 1'b1;
               push_data = hold_data_q;
               push_cnt  = hold_cnt_q;
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         bit_idx_q   <= '0;
         shreg_q     <= '0;
         hold_data_q <= '0;
         hold_cnt_q  <= '0;
         ovf_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         bit_idx_q   <= bit_idx_d;
         shreg_q     <= shreg_d;
         hold_data_q <= hold_data_d;
         hold_cnt_q  <= hold_cnt_d;
         ovf_q       <= ovf_d;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            fifo_data_q[i] <= '0;
            fifo_cnt_q[i]  <= '0;
         end
      end else begin
         if (push) begin
            fifo_data_q[wr_ptr_q[AW-1:0]] <= push_data;
            fifo_cnt_q[wr_ptr_q[AW-1:0]]  <= push_cnt;
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      end
   end

   // Dropped verdicts still count toward the totals.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pass_q <= '0;
         fail_q <= '0;
      end else if (in_valid) begin
         if (in_result && pass_q != '1) pass_q <= pass_q + 1'b1;
         if (!in_result && fail_q != '1) fail_q <= fail_q + 1'b1;
      end
   end

   assign out_valid = !empty;
   assign out_data  = fifo_data_q[rd_ptr_q[AW-1:0]];
   assign out_count = fifo_cnt_q[rd_ptr_q[AW-1:0]];
   assign pass_cnt  = pass_q;
   assign fail_cnt  = fail_q;
   assign overflow  = ovf_q;
   assign busy      = (state_q != IDLE) || !empty;

endmodule

// File: tb/tb_rails_result_packer.sv
// Directed bench for rails_result_packer: packing, flush, backpressure,
// overflow, and reset during HOLD.
module tb_rails_result_packer;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_result = 1'b0;
   logic        flush = 1'b0;
   logic        out_ready = 1'b0;
   logic        out_valid;
   logic [7:0]  out_data;
   logic [3:0]  out_count;
   logic [15:0] pass_cnt;
   logic [15:0] fail_cnt;
   logic        overflow;
   logic        busy;

   int checks = 0;
   int failures = 0;

   rails_result_packer #(
      .PACK_W(8), .FIFO_DEPTH(4), .CNT_W(16)
   ) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_result(in_result),
      .flush(flush), .out_ready(out_ready),
      .out_valid(out_valid), .out_data(out_data),
      .out_count(out_count), .pass_cnt(pass_cnt),
      .fail_cnt(fail_cnt), .overflow(overflow), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic r, input logic f);
      in_valid  = 1'b1;
      in_result = r;
      flush     = f;
      step();
      in_valid  = 1'b0;
      flush     = 1'b0;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_valid"}, 32'(out_valid), 32'h0);
      chk({tag, "_data"}, 32'(out_data), 32'h0);
      chk({tag, "_count"}, 32'(out_count), 32'h0);
      chk({tag, "_pass"}, 32'(pass_cnt), 32'h0);
      chk({tag, "_fail"}, 32'(fail_cnt), 32'h0);
      chk({tag, "_ovf"}, 32'(overflow), 32'h0);
      chk({tag, "_busy"}, 32'(busy), 32'h0);
   endtask

   logic [7:0] v1 = 8'b0100_1101;
   logic [7:0] v6 = 8'b1001_0110;

   initial begin
      step();
      step();
      chk_zero("rst");
      reset = 1'b0;
      step();

      // 1: full word with consumer ready
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) send(v1[i], 1'b0);
      chk("t1_valid", 32'(out_valid), 32'h1);
      chk("t1_data", 32'(out_data), 32'h4D);
      chk("t1_count", 32'(out_count), 32'h8);
      chk("t1_pass", 32'(pass_cnt), 32'd4);
      chk("t1_fail", 32'(fail_cnt), 32'd4);
      chk("t1_ovf", 32'(overflow), 32'h0);
      step();
      chk("t1_popped", 32'(out_valid), 32'h0);

      // 2: partial word pushed by flush
      send(1'b1, 1'b0);
      send(1'b1, 1'b0);
      send(1'b0, 1'b0);
      chk("t2_nopush", 32'(out_valid), 32'h0);
      chk("t2_busy_collect", 32'(busy), 32'h1);
      flush = 1'b1;
      step();
      flush = 1'b0;
      chk("t2_valid", 32'(out_valid), 32'h1);
      chk("t2_data", 32'(out_data), 32'h03);
      chk("t2_count", 32'(out_count), 32'h3);
      step();
      chk("t2_busy", 32'(busy), 32'h0);

      // 3: flush together with a verdict
      send(1'b1, 1'b0);
      send(1'b0, 1'b0);
      send(1'b1, 1'b1);
      chk("t3_data", 32'(out_data), 32'h05);
      chk("t3_count", 32'(out_count), 32'h3);
      step();
      chk("t3_pass", 32'(pass_cnt), 32'd8);
      chk("t3_fail", 32'(fail_cnt), 32'd6);

      // 4: flush while idle does nothing
      flush = 1'b1;
      step();
      flush = 1'b0;
      chk("t4_valid", 32'(out_valid), 32'h0);
      chk("t4_busy", 32'(busy), 32'h0);
      step();
      chk("t4_valid2", 32'(out_valid), 32'h0);

      // 5: backpressure, HOLD, overflow, drain
      out_ready = 1'b0;
      for (int i = 0; i < 40; i++) send(1'b1, 1'b0);
      chk("t5_busy_hold", 32'(busy), 32'h1);
      chk("t5_ovf_pre", 32'(overflow), 32'h0);
      send(1'b1, 1'b0);
      send(1'b1, 1'b0);
      chk("t5_ovf", 32'(overflow), 32'h1);
      chk("t5_pass", 32'(pass_cnt), 32'd50);
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("t5_v%0d", i), 32'(out_valid), 32'h1);
         chk($sformatf("t5_d%0d", i), 32'(out_data), 32'hFF);
         chk($sformatf("t5_c%0d", i), 32'(out_count), 32'h8);
         step();
      end
      chk("t5_empty", 32'(out_valid), 32'h0);
      chk("t5_busy", 32'(busy), 32'h0);
      chk("t5_ovf_sticky", 32'(overflow), 32'h1);

      // 6: reset during HOLD
      out_ready = 1'b0;
      for (int i = 0; i < 40; i++) send(1'b0, 1'b0);
      chk("t6_busy", 32'(busy), 32'h1);
      reset = 1'b1;
      #1;
      chk_zero("t6_rst");
      #2;
      reset = 1'b0;
      step();
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) send(v6[i], 1'b0);
      chk("t6_data", 32'(out_data), 32'h96);
      chk("t6_count", 32'(out_count), 32'h8);
      chk("t6_pass", 32'(pass_cnt), 32'd4);
      chk("t6_fail", 32'(fail_cnt), 32'd4);
      chk("t6_ovf", 32'(overflow), 32'h0);
      step();
      chk("t6_empty", 32'(out_valid), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
